// File: rtl/board_controller.sv
// board_controller: debounced two-button paddle mover with per-frame stepping, acceleration and edge clamps
//   clk        system clock
//   reset      asynchronous active-low reset
//   btn_left   raw left button (async, bouncy)
//   btn_right  raw right button (async, bouncy)
//   pause      freezes board position and acceleration
//   x, y       VGA scan position, used to derive the once-per-frame refresh tick
//   board_x    board left edge; board_y constant board top
//   moving     board steps on the next refresh tick
//   at_left    board sits at column 0; at_right board sits at the rightmost legal column
module board_controller #(
  parameter int X_MAX           = 639,
  parameter int BOARD_WIDTH     = 64,
  parameter int BOARD_Y         = 440,
  parameter int BOARD_X_INIT    = 288,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SPEED_MIN       = 1,
  parameter int SPEED_MAX       = 8,
  parameter int ACCEL_TICKS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       pause,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] board_x,
  output logic [9:0] board_y,
  output logic       moving,
  output logic       at_left,
  output logic       at_right
);
  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;
  localparam int XR = X_MAX + 1 - BOARD_WIDTH;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SPEED_MAX + 1);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  logic [1:0] sl_q, sl_d, sr_q, sr_d;
  logic dbl_q, dbl_d, dbr_q, dbr_d;
  logic [CW-1:0] cntl_q, cntl_d, cntr_q, cntr_d;
  logic cond_q, cond_d;
  state_t state_q, state_d;
  logic [SW-1:0] speed_q, speed_d, spd;
  logic [HW-1:0] hold_q, hold_d, hld;
  logic [9:0] board_x_q, board_x_d, nx_l, nx_r;
  logic moving_q, moving_d, at_left_q, at_left_d, at_right_q, at_right_d;
  logic diff_l, diff_r, done_l, done_r, tick, restart, step, wrap;
  logic [10:0] dif, sum;
  always_comb begin
    sl_d = {sl_q[0], btn_left};
    sr_d = {sr_q[0], btn_right};
    diff_l = sl_q[1] ^ dbl_q;
    diff_r = sr_q[1] ^ dbr_q;
    done_l = diff_l && cntl_q == CW'(DEBOUNCE_CYCLES - 1);
    done_r = diff_r && cntr_q == CW'(DEBOUNCE_CYCLES - 1);
    dbl_d = dbl_q ^ done_l;
    dbr_d = dbr_q ^ done_r;
    cntl_d = (diff_l && !done_l) ? cntl_q + 1'b1 : '0;
    cntr_d = (diff_r && !done_r) ? cntr_q + 1'b1 : '0;
    cond_d = (y == 10'd481) && (x == 10'd0);
    tick = cond_d && !cond_q;
    state_d = (dbl_q == dbr_q) ? IDLE : dbl_q ? MOVE_L : MOVE_R;
    // a direction change or IDLE restarts acceleration in the same cycle, so a coincident tick uses SPEED_MIN
    restart = (state_d != state_q) || (state_d == IDLE);
    spd = restart ? SW'(SPEED_MIN) : speed_q;
    hld = restart ? '0 : hold_q;
    step = tick && !pause && (state_d != IDLE);
    // 11-bit arithmetic: bit 10 of dif flags an underflow past column 0
    dif = {1'b0, board_x_q} - 11'(spd);
    sum = {1'b0, board_x_q} + 11'(spd);
    nx_l = dif[10] ? 10'd0 : dif[9:0];
    nx_r = (sum > 11'(XR)) ? 10'(XR) : sum[9:0];
    board_x_d = !step ? board_x_q : (state_d == MOVE_L) ? nx_l : nx_r;
    wrap = hld == HW'(ACCEL_TICKS - 1);
    hold_d = !step ? hld : wrap ? '0 : hld + 1'b1;
    speed_d = (!step || !wrap || spd >= SW'(SPEED_MAX)) ? spd : spd + 1'b1;
    moving_d = (state_d != IDLE) && !pause;
    at_left_d = board_x_d == 10'd0;
    at_right_d = board_x_d == 10'(XR);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sl_q       <= '0;
      sr_q       <= '0;
      dbl_q      <= 1'b0;
      dbr_q      <= 1'b0;
      cntl_q     <= '0;
      cntr_q     <= '0;
      cond_q     <= 1'b0;
      state_q    <= IDLE;
      speed_q    <= SW'(SPEED_MIN);
      hold_q     <= '0;
      board_x_q  <= 10'(BOARD_X_INIT);
      moving_q   <= 1'b0;
      at_left_q  <= 1'b0;
      at_right_q <= 1'b0;
    end else begin
      sl_q       <= sl_d;
      sr_q       <= sr_d;
      dbl_q      <= dbl_d;
      dbr_q      <= dbr_d;
      cntl_q     <= cntl_d;
      cntr_q     <= cntr_d;
      cond_q     <= cond_d;
      state_q    <= state_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      board_x_q  <= board_x_d;
      moving_q   <= moving_d;
      at_left_q  <= at_left_d;
      at_right_q <= at_right_d;
    end
  end
  assign board_x  = board_x_q;
  assign board_y  = 10'(BOARD_Y);
  assign moving   = moving_q;
  assign at_left  = at_left_q;
  assign at_right = at_right_q;
endmodule
